// File: rtl/i2c_slave.sv
// I2C register-file target: 7-bit address, 8-bit auto-incrementing register pointer.
// SCL/SDA are oversampled on clk; START/STOP and SCL edges are decoded from synchronised copies.
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h69,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [7:0]  RESET_VAL  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_stb,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0]  LP_NREGS = 9'(NUM_REGS);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_REG, S_WDATA, S_RDATA} state_t;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    state_t     r_state;
    logic [3:0] r_bitcnt;
    logic [6:0] r_shift;
    logic [6:0] r_tx;
    logic [7:0] r_ptr;
    logic       r_ack;
    logic       r_rw;
    logic [7:0] r_mem [NUM_REGS];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_ptr_ok;
    logic [7:0] w_byte, w_rd_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= '1;
            {r_sda_s1, r_sda_s2, r_sda_d} <= '1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_ptr_ok   = ({1'b0, r_ptr} < LP_NREGS);
    assign w_rd_byte  = w_ptr_ok ? r_mem[r_ptr[IDX_W-1:0]] : 8'hFF;

    // r_bitcnt: 0..7 data bits, 8 = ACK slot pending, 9 = ACK slot on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= '0;
            r_ptr    <= '0;
            r_ack    <= 1'b0;
            r_rw     <= 1'b0;
            sda_oe   <= 1'b0;
            wr_stb   <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
        end else begin
            wr_stb <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
            end else begin
                unique case (r_state)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (w_scl_rise && r_bitcnt < 4'd8) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_ack <= 1'b1;
                                if (r_state == S_ADDR) begin
                                    if (w_byte[7:1] == SLAVE_ADDR) begin
                                        busy <= 1'b1;
                                        r_rw <= w_byte[0];
                                    end else begin
                                        r_state <= S_IDLE;
                                        busy    <= 1'b0;
                                        r_ack   <= 1'b0;
                                    end
                                end else if (r_state == S_REG) begin
                                    r_ptr <= w_byte;
                                end else begin
                                    r_ptr <= r_ptr + 8'd1;
                                    if (w_ptr_ok) begin
                                        r_mem[r_ptr[IDX_W-1:0]] <= w_byte;
                                        wr_stb  <= 1'b1;
                                        wr_reg  <= r_ptr;
                                        wr_data <= w_byte;
                                    end else begin
                                        r_ack <= 1'b0;
                                    end
                                end
                            end
                        end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                            sda_oe   <= r_ack;
                            r_bitcnt <= 4'd9;
                        end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                            r_bitcnt <= '0;
                            sda_oe   <= 1'b0;
                            if (r_state == S_ADDR && r_rw) begin
                                // first read byte goes out on the same fall that ends the ACK
                                r_state <= S_RDATA;
                                sda_oe  <= ~w_rd_byte[7];
                                r_tx    <= w_rd_byte[6:0];
                            end else if (r_state == S_ADDR) begin
                                r_state <= S_REG;
                            end else if (r_state == S_REG) begin
                                r_state <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt < 4'd7) begin
                                sda_oe   <= ~r_tx[6];
                                r_tx     <= {r_tx[5:0], 1'b0};
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end else if (r_bitcnt == 4'd7) begin
                                sda_oe   <= 1'b0;
                                r_bitcnt <= 4'd8;
                            end else if (r_bitcnt == 4'd9) begin
                                sda_oe   <= ~w_rd_byte[7];
                                r_tx     <= w_rd_byte[6:0];
                                r_bitcnt <= '0;
                            end
                        end else if (w_scl_rise && r_bitcnt == 4'd8) begin
                            r_ptr <= r_ptr + 8'd1;
                            if (r_sda_s2) begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_bitcnt <= 4'd9;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: an I2C master model drives the bus, expected
// write strobes and read bytes are queued and checked by a separate monitor.
module tb_i2c_slave;
    localparam int Q = 100;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   stb_cnt = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] act_rd[$];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h69), .NUM_REGS(16), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl    (m_scl),
        .sda_in (sda_bus),
        .sda_oe (sda_oe),
        .wr_stb (wr_stb),
        .wr_reg (wr_reg),
        .wr_data(wr_data),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares DUT strobes and observed read bytes against the queues
    initial begin
        wr_t        e;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (wr_stb) begin
                stb_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr_stb", wr_reg, 8'hXX);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_reg", wr_reg, e.r);
                    chk("wr_data", wr_data, e.d);
                end
            end
            if (act_rd.size() != 0) begin
                a = act_rd.pop_front();
                if (exp_rd.size() == 0) chk("unexpected_rd", a, 8'hXX);
                else chk("rd_data", a, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; #Q;
            m_scl = 1'b1; #(2 * Q);
            m_scl = 1'b0; #Q;
        end
    endtask

    task automatic wr_exp(input string name, input logic [7:0] b, input logic exp_nack);
        logic ack;
        send_bits(b, 8);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        ack = sda_bus; #Q;
        m_scl = 1'b0; #Q;
        chk(name, 8'(ack), 8'(exp_nack));
    endtask

    task automatic rd_exp(input logic nack, input logic [7:0] exp);
        logic [7:0] b;
        exp_rd.push_back(exp);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; m_scl = 1'b1;
            #Q; b[i] = sda_bus;
            #Q; m_scl = 1'b0;
            #Q;
        end
        m_sda = nack; #Q;
        m_scl = 1'b1; #(2 * Q);
        m_scl = 1'b0; #Q;
        act_rd.push_back(b);
    endtask

    task automatic push_wr(input logic [7:0] r, input logic [7:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    initial begin
        int stb_before;
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        #53;
        chk("rst_sda_oe", 8'(sda_oe), 8'h00);
        chk("rst_wr_stb", 8'(wr_stb), 8'h00);
        chk("rst_wr_reg", wr_reg, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        rst = 1'b0;
        #(2 * Q);

        // basic write mem[5]=3C, plus mem[7]=5A for the pointer-retention check
        i2c_start();
        wr_exp("ack_addr_w", 8'hD2, 1'b0);
        chk("busy_after_match", 8'(busy), 8'h01);
        wr_exp("ack_reg_05", 8'h05, 1'b0);
        push_wr(8'h05, 8'h3C);
        wr_exp("ack_data_3c", 8'h3C, 1'b0);
        i2c_stop();
        chk("busy_after_stop", 8'(busy), 8'h00);
        i2c_start();
        wr_exp("ack_addr_w2", 8'hD2, 1'b0);
        wr_exp("ack_reg_07", 8'h07, 1'b0);
        push_wr(8'h07, 8'h5A);
        wr_exp("ack_data_5a", 8'h5A, 1'b0);
        i2c_stop();

        // read-back through repeated START
        i2c_start();
        wr_exp("ack_addr_w3", 8'hD2, 1'b0);
        wr_exp("ack_reg_05b", 8'h05, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r", 8'hD3, 1'b0);
        rd_exp(1'b0, 8'h3C);
        rd_exp(1'b1, 8'h00);
        chk("sda_released_after_nack", 8'(sda_oe), 8'h00);
        chk("busy_after_nack", 8'(busy), 8'h00);
        i2c_stop();
        i2c_start();
        wr_exp("ack_addr_r2", 8'hD3, 1'b0);
        rd_exp(1'b1, 8'h5A);
        i2c_stop();

        // address mismatch
        oe_seen    = 1'b0;
        busy_seen  = 1'b0;
        stb_before = stb_cnt;
        i2c_start();
        wr_exp("nack_addr_d4", 8'hD4, 1'b1);
        wr_exp("nack_after_mismatch1", 8'h05, 1'b1);
        wr_exp("nack_after_mismatch2", 8'hAA, 1'b1);
        i2c_stop();
        chk("mismatch_oe_seen", 8'(oe_seen), 8'h00);
        chk("mismatch_busy_seen", 8'(busy_seen), 8'h00);
        chk("mismatch_stb_cnt", 8'(stb_cnt), 8'(stb_before));

        // boundary: last register, out-of-range write/read, pointer wrap
        i2c_start();
        wr_exp("ack_addr_w4", 8'hD2, 1'b0);
        wr_exp("ack_reg_0f", 8'h0F, 1'b0);
        push_wr(8'h0F, 8'h11);
        wr_exp("ack_data_11", 8'h11, 1'b0);
        wr_exp("nack_data_22", 8'h22, 1'b1);
        i2c_stop();
        i2c_start();
        wr_exp("ack_addr_w5", 8'hD2, 1'b0);
        wr_exp("ack_reg_10", 8'h10, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r3", 8'hD3, 1'b0);
        rd_exp(1'b1, 8'hFF);
        i2c_stop();
        i2c_start();
        wr_exp("ack_addr_w6", 8'hD2, 1'b0);
        wr_exp("ack_reg_ff", 8'hFF, 1'b0);
        wr_exp("nack_data_77", 8'h77, 1'b1);
        push_wr(8'h00, 8'h99);
        wr_exp("ack_data_99_wrap", 8'h99, 1'b0);
        i2c_stop();
        i2c_start();
        wr_exp("ack_addr_w7", 8'hD2, 1'b0);
        wr_exp("ack_reg_ff2", 8'hFF, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r4", 8'hD3, 1'b0);
        rd_exp(1'b0, 8'hFF);
        rd_exp(1'b1, 8'h99);
        i2c_stop();

        // reset while the slave drives bit 7 (0) of 0x3C
        i2c_start();
        wr_exp("ack_addr_w8", 8'hD2, 1'b0);
        wr_exp("ack_reg_05c", 8'h05, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r5", 8'hD3, 1'b0);
        chk("slave_drives_zero", 8'(sda_oe), 8'h01);
        #4;
        rst = 1'b1;
        #1;
        chk("async_rst_sda_oe", 8'(sda_oe), 8'h00);
        chk("async_rst_busy", 8'(busy), 8'h00);
        chk("async_rst_wr_data", wr_data, 8'h00);
        #50;
        rst   = 1'b0;
        m_sda = 1'b1;
        m_scl = 1'b1;
        #(2 * Q);
        i2c_start();
        wr_exp("ack_addr_after_rst", 8'hD2, 1'b0);
        wr_exp("ack_reg_05d", 8'h05, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r6", 8'hD3, 1'b0);
        rd_exp(1'b1, 8'h00);
        i2c_stop();

        // STOP after 4 data bits
        i2c_start();
        wr_exp("ack_addr_w9", 8'hD2, 1'b0);
        wr_exp("ack_reg_02", 8'h02, 1'b0);
        push_wr(8'h02, 8'hA5);
        wr_exp("ack_data_a5", 8'hA5, 1'b0);
        i2c_stop();
        stb_before = stb_cnt;
        i2c_start();
        wr_exp("ack_addr_w10", 8'hD2, 1'b0);
        wr_exp("ack_reg_02b", 8'h02, 1'b0);
        send_bits(8'h50, 4);
        i2c_stop();
        chk("busy_after_mid_stop", 8'(busy), 8'h00);
        chk("mid_stop_stb_cnt", 8'(stb_cnt), 8'(stb_before));
        i2c_start();
        wr_exp("ack_addr_w11", 8'hD2, 1'b0);
        wr_exp("ack_reg_02c", 8'h02, 1'b0);
        i2c_start();
        wr_exp("ack_addr_r7", 8'hD3, 1'b0);
        rd_exp(1'b1, 8'hA5);
        i2c_stop();

        #(10 * Q);
        chk("exp_wr_drained", 8'(exp_wr.size()), 8'h00);
        chk("exp_rd_drained", 8'(exp_rd.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the team's I2C master: a 7-bit-addressed register slave with an 8-bit register pointer.
- Oversamples SCL/SDA with the system clock and decodes START, repeated START and STOP.
- Supports register-pointer writes, multi-byte writes and multi-byte reads, all with pointer auto-increment.
- Holds a small internal register file and issues a write strobe per accepted data byte, for use as a bench responder and as an on-chip peripheral front end.

Parameters:
- SLAVE_ADDR, 7'h69, 7-bit address this block responds to.
- NUM_REGS, 16, register file depth. Pointer values >= NUM_REGS are out of range.
- RESET_VAL, 8'h00, reset value of every register file entry.

Ports:
- clk  input  1  system clock; at least 8x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  bus SCL, asynchronous to clk.
- sda_in  input  1  bus SDA sense, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- wr_stb  output  1  one-clk pulse when a data byte is written.
- wr_reg  output  8  register pointer of the written byte.
- wr_data  output  8  written byte.
- busy  output  1  high from an address match until STOP or a NACK-terminated end.

Behaviour:
- Reset:
  - sda_oe=0, wr_stb=0, wr_reg=0, wr_data=0, busy=0.
  - Pointer=0, state=IDLE, all registers=RESET_VAL.
  - Asynchronous reset mid-transfer releases SDA immediately.
- Input sync and edge detect:
  - scl and sda_in each pass through a 2-FF synchronizer, then a third FF for edge detection.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - Data is sampled on SCL rise. sda_oe changes only on SCL fall, one clk after detection.
- START or repeated START in any state: bit counter=0, go to ADDR.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7-bit address + R/W).
    - Match: busy=1. On the next SCL fall drive ACK (sda_oe=1); release on the following fall.
    - R/W=0 -> REG. R/W=1 -> RDATA.
    - Mismatch: no ACK, go to IDLE.
  - REG: shift 8 bits, load pointer, ACK, go to WDATA.
  - WDATA: shift 8 bits.
    - If pointer<NUM_REGS: store the byte and pulse wr_stb one clk after the 8th rising edge, with wr_reg=pointer and wr_data=byte. ACK.
    - Else: NACK and drop the byte, no wr_stb.
    - Pointer increments by 1 (8-bit wrap 8'hFF->8'h00). Remain in WDATA.
  - RDATA:
    - On the SCL fall that ends the ACK phase, load mem[pointer] (8'hFF if out of range).
    - Drive bit 7 (sda_oe = ~bit). Shift on each subsequent fall.
    - After the 8th bit, release SDA on the next fall, sample the master ACK on the rise, pointer++.
    - Master ACK (SDA=0): load the next byte, continue.
    - Master NACK: go to IDLE, sda_oe=0.
- Pointer is retained across transactions; a read with no pointer write starts at the last pointer value.
- No clock stretching; sda_oe is never asserted while SCL is high except during ACK and data phases held over from the preceding fall.

Test Plan:
- Write 0xD2 (7'h69,W), 0x05, 0x3C, STOP -> ACK on all three bytes; wr_stb once with wr_reg=0x05, wr_data=0x3C; mem[5]=0x3C; busy low after STOP.
- Read-back: START, 0xD2, 0x05, repeated START, 0xD3, master ACK then NACK -> slave returns 0x3C, then mem[6] (RESET_VAL 0x00); SDA released after the NACK; pointer=0x07.
- Address mismatch: START, 0xD4, 0x05, 0xAA, STOP -> sda_oe never asserted, no wr_stb, busy stays 0.
- Boundary: pointer 0x0F, write 0x11, 0x22 -> 0x11 ACKed into mem[15]; 0x22 NACKed with no strobe; reading pointer 0x10 returns 0xFF; pointer wrap 0xFF->0x00 verified.
- Reset mid-read while slave drives a 0 bit -> sda_oe=0 within the same cycle, state IDLE, mem=RESET_VAL; the next 0xD2 transaction is ACKed normally.
- STOP mid-byte after 4 data bits -> no strobe, mem unchanged, busy=0.
